// File: rtl/controlador_barrido_combinacion_pkg.sv
// pkg_combinacion: shared widths, member mask and FSM encoding for the combination sweep controller
package pkg_combinacion;
  localparam int ANCHO = 6;
  localparam int TOTAL_CODIGOS = 64;
  localparam int MIEMBROS = 22;
  // bit n set <=> code n is one of the 22 members
  localparam logic [TOTAL_CODIGOS-1:0] MASCARA = 64'h003C_000B_C2F0_B42E;
  typedef enum logic [1:0] {REPOSO = 2'd0, BARRIDO = 2'd1, FIN = 2'd2} estado_t;
endpackage

// File: rtl/controlador_barrido_combinacion_comparador.sv
// Comparador22Numeros6Bit_Compuertas: combinational membership test of a 6-bit code
module Comparador22Numeros6Bit_Compuertas
  import pkg_combinacion::*;
(
  input  logic [ANCHO-1:0] codigo,
  output logic             pertenece
);
  assign pertenece = MASCARA[codigo];
endmodule

// File: rtl/controlador_barrido_combinacion.sv
// controlador_barrido_combinacion: stream/sweep sequencer around the member comparator with a registered valid/ready output
module controlador_barrido_combinacion
  import pkg_combinacion::*;
#(
  parameter int ANCHO     = 6,
  parameter int ANCHO_CNT = 7
) (
  input  logic                 Reloj,
  input  logic                 Reset_n,
  input  logic                 Modo,
  input  logic                 Inicio,
  input  logic                 Entrada_valida,
  input  logic [ANCHO-1:0]     Entrada,
  output logic                 Entrada_lista,
  output logic                 Salida_valida,
  input  logic                 Salida_lista,
  output logic [ANCHO-1:0]     Salida_dato,
  output logic                 Salida_pertenece,
  output logic [ANCHO_CNT-1:0] Cuenta,
  output logic                 Ocupado,
  output logic                 Hecho
);
  estado_t estado_q, estado_d;
  logic [ANCHO:0] dir_q, dir_d;
  logic valida_q, valida_d, pert_q, pert_d;
  logic [ANCHO-1:0] dato_q, dato_d, codigo;
  logic [ANCHO_CNT-1:0] cuenta_q, cuenta_d;
  logic pert, xfer, libre, arranque, carga;
  assign codigo = (estado_q == BARRIDO) ? dir_q[ANCHO-1:0] : Entrada;
  Comparador22Numeros6Bit_Compuertas u_comparador (.codigo(codigo), .pertenece(pert));
  always_comb begin
    estado_d = estado_q;
    dir_d = dir_q;
    valida_d = valida_q;
    dato_d = dato_q;
    pert_d = pert_q;
    cuenta_d = cuenta_q;
    xfer = valida_q & Salida_lista;
    libre = !valida_q | Salida_lista;
    arranque = (estado_q == REPOSO) && Inicio && Modo;
    Entrada_lista = Reset_n && (estado_q == REPOSO) && !arranque && libre;
    // the 7-bit address reaching 64 means code 63 is already in the output register
    carga = (estado_q == REPOSO) ? Entrada_valida && Entrada_lista
          : (estado_q == BARRIDO) && libre && !dir_q[ANCHO];
    if (xfer) valida_d = 1'b0;
    if (carga) begin
      valida_d = 1'b1;
      dato_d = codigo;
      pert_d = pert;
    end
    if (xfer && pert_q && cuenta_q != '1) cuenta_d = cuenta_q + 1'b1;
    if ((estado_q == REPOSO) && Inicio) cuenta_d = '0;
    if (arranque) begin
      estado_d = BARRIDO;
      dir_d = '0;
    end
    if (estado_q == BARRIDO) begin
      if (carga) dir_d = dir_q + 1'b1;
      if (dir_q[ANCHO] && xfer) estado_d = FIN;
    end
    if (estado_q == FIN) estado_d = REPOSO;
  end
  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      estado_q <= REPOSO;
      dir_q <= '0;
      valida_q <= 1'b0;
      dato_q <= '0;
      pert_q <= 1'b0;
      cuenta_q <= '0;
    end else begin
      estado_q <= estado_d;
      dir_q <= dir_d;
      valida_q <= valida_d;
      dato_q <= dato_d;
      pert_q <= pert_d;
      cuenta_q <= cuenta_d;
    end
  end
  assign Salida_valida = valida_q;
  assign Salida_dato = dato_q;
  assign Salida_pertenece = pert_q;
  assign Cuenta = cuenta_q;
  assign Ocupado = (estado_q == BARRIDO);
  assign Hecho = (estado_q == FIN);
endmodule

// File: tb/tb_controlador_barrido_combinacion.sv
// tb_controlador_barrido_combinacion: scoreboard bench for the combination sweep controller
module tb_controlador_barrido_combinacion;
  logic Reloj = 0, Reset_n = 0, Modo = 0, Inicio = 0, Entrada_valida = 0, Salida_lista = 1;
  logic [5:0] Entrada = 0;
  logic Entrada_lista, Salida_valida, Salida_pertenece, Ocupado, Hecho;
  logic [5:0] Salida_dato;
  logic [6:0] Cuenta;
  int tests = 0, fails = 0, xfers = 0;
  logic [6:0] sb[$];
  logic prev_stall = 0;
  logic [6:0] prev_out;
  int miembros[22] = '{1,2,3,5,10,12,13,15,20,21,22,23,25,30,31,32,33,35,50,51,52,53};

  controlador_barrido_combinacion dut (
    .Reloj(Reloj), .Reset_n(Reset_n), .Modo(Modo), .Inicio(Inicio),
    .Entrada_valida(Entrada_valida), .Entrada(Entrada), .Entrada_lista(Entrada_lista),
    .Salida_valida(Salida_valida), .Salida_lista(Salida_lista), .Salida_dato(Salida_dato),
    .Salida_pertenece(Salida_pertenece), .Cuenta(Cuenta), .Ocupado(Ocupado), .Hecho(Hecho));

  always #5 Reloj = ~Reloj;

  function automatic void chk(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  function automatic logic es_miembro(int c);
    foreach (miembros[i]) if (miembros[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge Reloj) begin
    if (!Reset_n) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", Salida_valida, 1);
        chk("stall_hold", {Salida_pertenece, Salida_dato}, prev_out);
      end
      if (Salida_valida && Salida_lista) begin
        xfers++;
        if (sb.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          logic [6:0] e;
          e = sb.pop_front();
          chk("dato", Salida_dato, e[5:0]);
          chk("pertenece", Salida_pertenece, e[6]);
        end
      end
      prev_stall <= Salida_valida && !Salida_lista;
      prev_out <= {Salida_pertenece, Salida_dato};
    end
  end

  task automatic send(input logic [5:0] c, input logic p);
    logic ok;
    Entrada_valida = 1;
    Entrada = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge Reloj);
      ok = Entrada_lista;
      @(posedge Reloj);
      if (ok) begin
        sb.push_back({p, c});
        #1;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    #1;
  endtask

  task automatic start_sweep();
    Modo = 1;
    Inicio = 1;
    @(posedge Reloj);
    for (int c = 0; c < 64; c++) sb.push_back({es_miembro(c), 6'(c)});
    #1;
    Inicio = 0;
  endtask

  task automatic wait_hecho(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Reloj);
      n++;
      if (Hecho) return;
    end
    chk("hecho_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Reloj);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n, base;
    repeat (2) @(posedge Reloj);
    @(negedge Reloj);
    chk("rst_lista", Entrada_lista, 0);
    chk("rst_valida", Salida_valida, 0);
    chk("rst_cuenta", Cuenta, 0);
    #1 Reset_n = 1;
    @(posedge Reloj);
    #1;
    // stream, full throughput
    send(1, 1); send(4, 0); send(53, 1); send(54, 0); send(63, 0); send(32, 1);
    Entrada_valida = 0;
    drain();
    @(negedge Reloj);
    chk("stream_cuenta", Cuenta, 3);
    // stream backpressure
    @(posedge Reloj);
    #1 Salida_lista = 0;
    send(25, 1);
    Entrada = 26;
    for (int i = 0; i < 3; i++) begin
      @(negedge Reloj);
      chk("bp_lista", Entrada_lista, 0);
      chk("bp_dato", Salida_dato, 25);
      chk("bp_pert", Salida_pertenece, 1);
      @(posedge Reloj);
    end
    #1 Salida_lista = 1;
    @(negedge Reloj);
    chk("bp_drain_lista", Entrada_lista, 1);
    @(posedge Reloj);
    sb.push_back({1'b0, 6'd26});
    #1 Entrada_valida = 0;
    drain();
    chk("bp_cuenta", Cuenta, 4);
    // reset mid-sweep
    @(posedge Reloj);
    #1;
    base = xfers;
    start_sweep();
    for (int i = 0; i < 100 && xfers < base + 10; i++) @(negedge Reloj);
    chk("sweep_xfers", xfers - base, 10);
    @(posedge Reloj);
    #1 Reset_n = 0;
    @(negedge Reloj);
    chk("midrst_lista", Entrada_lista, 0);
    @(posedge Reloj);
    @(negedge Reloj);
    sb.delete();
    chk("midrst_valida", Salida_valida, 0);
    chk("midrst_dato", Salida_dato, 0);
    chk("midrst_pert", Salida_pertenece, 0);
    chk("midrst_cuenta", Cuenta, 0);
    chk("midrst_ocupado", Ocupado, 0);
    chk("midrst_hecho", Hecho, 0);
    @(posedge Reloj);
    #1 Reset_n = 1;
    @(negedge Reloj);
    chk("midrst_reposo", Entrada_lista, 1);
    // full-speed sweep
    @(posedge Reloj);
    #1 start_sweep();
    @(negedge Reloj);
    chk("sweep_ocupado", Ocupado, 1);
    wait_hecho(n);
    chk("sweep_cycles", n, 65);
    @(negedge Reloj);
    chk("hecho_pulse", Hecho, 0);
    chk("sweep_idle", Ocupado, 0);
    chk("sweep_cuenta", Cuenta, 22);
    chk("sweep_sb", sb.size(), 0);
    // sweep with random backpressure
    @(posedge Reloj);
    #1 start_sweep();
    for (int i = 0; i < 1000; i++) begin
      @(negedge Reloj);
      if (Hecho) break;
      @(posedge Reloj);
      #1 Salida_lista = ($urandom_range(0, 9) >= 3);
    end
    chk("rnd_hecho", Hecho, 1);
    Salida_lista = 1;
    chk("rnd_cuenta", Cuenta, 22);
    chk("rnd_sb", sb.size(), 0);
    // Inicio during BARRIDO and in FIN is ignored
    @(posedge Reloj);
    #1 start_sweep();
    repeat (6) @(posedge Reloj);
    #1 Modo = 0; Inicio = 1;
    @(posedge Reloj);
    #1 Inicio = 0;
    repeat (4) @(posedge Reloj);
    #1 Modo = 1; Inicio = 1;
    @(posedge Reloj);
    #1 Inicio = 0;
    wait_hecho(n);
    Inicio = 1;
    @(posedge Reloj);
    #1 Inicio = 0;
    @(negedge Reloj);
    chk("fin_inicio_ignored", Ocupado, 0);
    chk("busy_cuenta", Cuenta, 22);
    chk("busy_sb", sb.size(), 0);
    // clear wins over a coinciding member transfer
    @(posedge Reloj);
    #1 Salida_lista = 0;
    send(1, 1);
    Entrada_valida = 0;
    Salida_lista = 1;
    Modo = 0;
    Inicio = 1;
    @(posedge Reloj);
    #1 Inicio = 0;
    @(negedge Reloj);
    chk("clear_wins", Cuenta, 0);
    chk("clear_sb", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
